// File: rtl/riscv_imem_arbiter.sv
// Two-port instruction-memory arbiter: round-robin request merge with an in-order
// ID FIFO that steers each memory response back to the port that issued it.
module riscv_imem_arbiter #(
    parameter int P_DEPTH = 4,
    parameter int P_CW    = $clog2(P_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,

    input  logic [66:0]     imemreq0_msg,
    input  logic            imemreq0_val,
    output logic            imemreq0_rdy,

    input  logic [66:0]     imemreq1_msg,
    input  logic            imemreq1_val,
    output logic            imemreq1_rdy,

    output logic [66:0]     memreq_msg,
    output logic            memreq_val,
    input  logic            memreq_rdy,

    input  logic [34:0]     memresp_msg,
    input  logic            memresp_val,

    output logic [34:0]     imemresp0_msg,
    output logic            imemresp0_val,
    output logic [34:0]     imemresp1_msg,
    output logic            imemresp1_val,

    output logic [P_CW-1:0] outstanding,
    output logic            err_orphan
);

    localparam int               AW      = $clog2(P_DEPTH);
    localparam logic [P_CW-1:0]  DEPTH_C = P_CW'(P_DEPTH);
    localparam logic [P_CW-1:0]  CNT_ONE = P_CW'(1);
    localparam logic [AW-1:0]    PTR_ONE = AW'(1);

    // last_grant = 1 means port 1 won most recently, so port 0 is favoured next
    logic               last_grant;
    logic [P_DEPTH-1:0] id_mem;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [P_CW-1:0]    count;
    logic               err_flag;

    logic grant0;
    logic grant1;
    logic full;
    logic empty;
    logic fire0;
    logic fire1;
    logic push;
    logic push_id;
    logic pop;
    logic head_id;
    logic orphan;

    assign grant0 = imemreq0_val & (!imemreq1_val | last_grant);
    assign grant1 = imemreq1_val & (!imemreq0_val | !last_grant);

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // Request side is gated by reset so nothing looks issuable while held in reset
    assign memreq_val   = reset & (imemreq0_val | imemreq1_val) & !full;
    assign memreq_msg   = grant1 ? imemreq1_msg : imemreq0_msg;
    assign imemreq0_rdy = reset & grant0 & memreq_rdy & !full;
    assign imemreq1_rdy = reset & grant1 & memreq_rdy & !full;

    assign fire0   = imemreq0_rdy & imemreq0_val;
    assign fire1   = imemreq1_rdy & imemreq1_val;
    assign push    = fire0 | fire1;
    assign push_id = fire1;

    assign head_id = id_mem[rd_ptr];
    assign pop     = memresp_val & !empty;
    assign orphan  = memresp_val & empty;

    assign imemresp0_msg = memresp_msg;
    assign imemresp1_msg = memresp_msg;
    assign imemresp0_val = pop & !head_id;
    assign imemresp1_val = pop & head_id;

    assign outstanding = count;
    assign err_orphan  = err_flag;

    // Pop never frees a slot for a same-cycle push: full blocks push via rdy above
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
            id_mem     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_flag   <= 1'b0;
        end else begin
            if (push) begin
                id_mem[wr_ptr] <= push_id;
                wr_ptr         <= wr_ptr + PTR_ONE;
                last_grant     <= push_id;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (!push && pop) begin
                count <= count - CNT_ONE;
            end
            if (orphan) begin
                err_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_imem_arbiter.sv
// Directed table-driven bench for riscv_imem_arbiter (P_DEPTH = 4) plus
// hand-written reset and first-fire sequences.
module tb_riscv_imem_arbiter;

    logic        clk;
    logic        reset;
    logic [66:0] imemreq0_msg;
    logic        imemreq0_val;
    logic        imemreq0_rdy;
    logic [66:0] imemreq1_msg;
    logic        imemreq1_val;
    logic        imemreq1_rdy;
    logic [66:0] memreq_msg;
    logic        memreq_val;
    logic        memreq_rdy;
    logic [34:0] memresp_msg;
    logic        memresp_val;
    logic [34:0] imemresp0_msg;
    logic        imemresp0_val;
    logic [34:0] imemresp1_msg;
    logic        imemresp1_val;
    logic [2:0]  outstanding;
    logic        err_orphan;

    int errors = 0;
    int checks = 0;

    riscv_imem_arbiter #(.P_DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .imemreq0_msg  (imemreq0_msg),
        .imemreq0_val  (imemreq0_val),
        .imemreq0_rdy  (imemreq0_rdy),
        .imemreq1_msg  (imemreq1_msg),
        .imemreq1_val  (imemreq1_val),
        .imemreq1_rdy  (imemreq1_rdy),
        .memreq_msg    (memreq_msg),
        .memreq_val    (memreq_val),
        .memreq_rdy    (memreq_rdy),
        .memresp_msg   (memresp_msg),
        .memresp_val   (memresp_val),
        .imemresp0_msg (imemresp0_msg),
        .imemresp0_val (imemresp0_val),
        .imemresp1_msg (imemresp1_msg),
        .imemresp1_val (imemresp1_val),
        .outstanding   (outstanding),
        .err_orphan    (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [31:0] a0;
        logic        v1;
        logic [31:0] a1;
        logic        mrdy;
        logic        rval;
        logic [31:0] rdata;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        e_mval;
        logic [31:0] e_addr;
        logic        e_r0;
        logic        e_r1;
        logic [2:0]  e_cnt;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [66:0] reqMsg(input logic [31:0] addr);
        return {1'b0, addr, 2'b00, 32'h0};
    endfunction

    function automatic vec_t mkv(
        input logic v0, input logic [31:0] a0, input logic v1, input logic [31:0] a1,
        input logic mrdy, input logic rval, input logic [31:0] rdata,
        input logic e_rdy0, input logic e_rdy1, input logic e_mval, input logic [31:0] e_addr,
        input logic e_r0, input logic e_r1, input logic [2:0] e_cnt, input logic e_err);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.v1 = v1; v.a1 = a1; v.mrdy = mrdy;
        v.rval = rval; v.rdata = rdata;
        v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_mval = e_mval; v.e_addr = e_addr;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_cnt = e_cnt; v.e_err = e_err;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [66:0] act, input logic [66:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        imemreq0_val = v.v0;
        imemreq0_msg = reqMsg(v.a0);
        imemreq1_val = v.v1;
        imemreq1_msg = reqMsg(v.a1);
        memreq_rdy   = v.mrdy;
        memresp_val  = v.rval;
        memresp_msg  = {3'b000, v.rdata};
    endtask

    task automatic checkVector(input int i, input vec_t v);
        checkOutput($sformatf("v%0d rdy0", i), imemreq0_rdy, v.e_rdy0);
        checkOutput($sformatf("v%0d rdy1", i), imemreq1_rdy, v.e_rdy1);
        checkOutput($sformatf("v%0d memreq_val", i), memreq_val, v.e_mval);
        if (v.e_mval)
            checkOutput($sformatf("v%0d memreq_msg", i), memreq_msg, reqMsg(v.e_addr));
        checkOutput($sformatf("v%0d resp0_val", i), imemresp0_val, v.e_r0);
        checkOutput($sformatf("v%0d resp1_val", i), imemresp1_val, v.e_r1);
        checkOutput($sformatf("v%0d resp0_msg", i), imemresp0_msg, {3'b000, v.rdata});
        checkOutput($sformatf("v%0d resp1_msg", i), imemresp1_msg, {3'b000, v.rdata});
        checkOutput($sformatf("v%0d outstanding", i), outstanding, v.e_cnt);
        checkOutput($sformatf("v%0d err_orphan", i), err_orphan, v.e_err);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Expected outstanding/err are the values visible during the cycle, before its edge
        //                v0  a0       v1  a1       rdy rv  rdata     r0  r1  mv  addr     o0  o1  cnt   err
        vecs.push_back(mkv(1, 32'h100, 1, 32'h104, 1, 0, 32'h0,     1, 0, 1, 32'h100, 0, 0, 3'd0, 0));
        vecs.push_back(mkv(1, 32'h100, 1, 32'h104, 1, 0, 32'h0,     0, 1, 1, 32'h104, 0, 0, 3'd1, 0));
        vecs.push_back(mkv(0, 32'h0,   0, 32'h0,   1, 1, 32'hAAAA,  0, 0, 0, 32'h0,   1, 0, 3'd2, 0));
        vecs.push_back(mkv(0, 32'h0,   0, 32'h0,   1, 1, 32'hBBBB,  0, 0, 0, 32'h0,   0, 1, 3'd1, 0));
        vecs.push_back(mkv(0, 32'h0,   0, 32'h0,   1, 0, 32'h0,     0, 0, 0, 32'h0,   0, 0, 3'd0, 0));
        vecs.push_back(mkv(1, 32'h200, 0, 32'h0,   1, 0, 32'h0,     1, 0, 1, 32'h200, 0, 0, 3'd0, 0));
        vecs.push_back(mkv(1, 32'h204, 0, 32'h0,   1, 0, 32'h0,     1, 0, 1, 32'h204, 0, 0, 3'd1, 0));
        vecs.push_back(mkv(1, 32'h208, 0, 32'h0,   1, 0, 32'h0,     1, 0, 1, 32'h208, 0, 0, 3'd2, 0));
        vecs.push_back(mkv(1, 32'h20C, 0, 32'h0,   1, 0, 32'h0,     1, 0, 1, 32'h20C, 0, 0, 3'd3, 0));
        vecs.push_back(mkv(1, 32'h210, 0, 32'h0,   1, 0, 32'h0,     0, 0, 0, 32'h0,   0, 0, 3'd4, 0));
        vecs.push_back(mkv(1, 32'h210, 0, 32'h0,   1, 1, 32'hCCCC,  0, 0, 0, 32'h0,   1, 0, 3'd4, 0));
        vecs.push_back(mkv(1, 32'h210, 0, 32'h0,   1, 0, 32'h0,     1, 0, 1, 32'h210, 0, 0, 3'd3, 0));
        vecs.push_back(mkv(0, 32'h0,   0, 32'h0,   1, 0, 32'h0,     0, 0, 0, 32'h0,   0, 0, 3'd4, 0));
        vecs.push_back(mkv(0, 32'h0,   0, 32'h0,   1, 1, 32'hD1,    0, 0, 0, 32'h0,   1, 0, 3'd4, 0));
        vecs.push_back(mkv(0, 32'h0,   0, 32'h0,   1, 1, 32'hD2,    0, 0, 0, 32'h0,   1, 0, 3'd3, 0));
        vecs.push_back(mkv(0, 32'h0,   0, 32'h0,   1, 1, 32'hD3,    0, 0, 0, 32'h0,   1, 0, 3'd2, 0));
        vecs.push_back(mkv(0, 32'h0,   0, 32'h0,   1, 1, 32'hD4,    0, 0, 0, 32'h0,   1, 0, 3'd1, 0));
        vecs.push_back(mkv(0, 32'h0,   1, 32'h300, 1, 0, 32'h0,     0, 1, 1, 32'h300, 0, 0, 3'd0, 0));
        vecs.push_back(mkv(1, 32'h304, 0, 32'h0,   1, 1, 32'hE1,    1, 0, 1, 32'h304, 0, 1, 3'd1, 0));
        vecs.push_back(mkv(0, 32'h0,   0, 32'h0,   1, 1, 32'hE2,    0, 0, 0, 32'h0,   1, 0, 3'd1, 0));
        vecs.push_back(mkv(0, 32'h0,   1, 32'h308, 1, 0, 32'h0,     0, 1, 1, 32'h308, 0, 0, 3'd0, 0));
        vecs.push_back(mkv(0, 32'h0,   0, 32'h0,   1, 1, 32'hE3,    0, 0, 0, 32'h0,   0, 1, 3'd1, 0));
        vecs.push_back(mkv(1, 32'h100, 1, 32'h104, 0, 0, 32'h0,     0, 0, 1, 32'h100, 0, 0, 3'd0, 0));
        vecs.push_back(mkv(1, 32'h100, 1, 32'h104, 0, 0, 32'h0,     0, 0, 1, 32'h100, 0, 0, 3'd0, 0));
        vecs.push_back(mkv(1, 32'h100, 1, 32'h104, 0, 0, 32'h0,     0, 0, 1, 32'h100, 0, 0, 3'd0, 0));
        vecs.push_back(mkv(1, 32'h100, 1, 32'h104, 1, 0, 32'h0,     1, 0, 1, 32'h100, 0, 0, 3'd0, 0));
        vecs.push_back(mkv(0, 32'h0,   0, 32'h0,   1, 1, 32'hE4,    0, 0, 0, 32'h0,   1, 0, 3'd1, 0));
        vecs.push_back(mkv(0, 32'h0,   0, 32'h0,   1, 1, 32'hF0,    0, 0, 0, 32'h0,   0, 0, 3'd0, 0));
        vecs.push_back(mkv(0, 32'h0,   0, 32'h0,   1, 0, 32'h0,     0, 0, 0, 32'h0,   0, 0, 3'd0, 1));
        vecs.push_back(mkv(0, 32'h0,   0, 32'h0,   1, 1, 32'hF1,    0, 0, 0, 32'h0,   0, 0, 3'd0, 1));
        vecs.push_back(mkv(0, 32'h0,   0, 32'h0,   1, 0, 32'h0,     0, 0, 0, 32'h0,   0, 0, 3'd0, 1));

        // Reset state, with live inputs that must not leak through
        reset        = 1'b0;
        imemreq0_val = 1'b1;
        imemreq0_msg = reqMsg(32'h100);
        imemreq1_val = 1'b1;
        imemreq1_msg = reqMsg(32'h104);
        memreq_rdy   = 1'b1;
        memresp_val  = 1'b1;
        memresp_msg  = 35'h1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset memreq_val", memreq_val, 1'b0);
        checkOutput("reset rdy0", imemreq0_rdy, 1'b0);
        checkOutput("reset rdy1", imemreq1_rdy, 1'b0);
        checkOutput("reset resp0_val", imemresp0_val, 1'b0);
        checkOutput("reset resp1_val", imemresp1_val, 1'b0);
        checkOutput("reset outstanding", outstanding, 3'd0);
        checkOutput("reset err_orphan", err_orphan, 1'b0);
        imemreq0_val = 1'b0;
        imemreq1_val = 1'b0;
        memresp_val  = 1'b0;
        memresp_msg  = '0;
        reset        = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkVector(i, vecs[i]);
        end

        // Mid-operation reset clears the sticky error asynchronously
        @(posedge clk);
        #1;
        imemreq0_val = 1'b1;
        imemreq0_msg = reqMsg(32'h400);
        imemreq1_val = 1'b1;
        imemreq1_msg = reqMsg(32'h404);
        memreq_rdy   = 1'b1;
        memresp_val  = 1'b1;
        memresp_msg  = 35'h77;
        reset        = 1'b0;
        #1;
        checkOutput("async rst err_orphan", err_orphan, 1'b0);
        checkOutput("async rst memreq_val", memreq_val, 1'b0);
        checkOutput("async rst rdy0", imemreq0_rdy, 1'b0);
        checkOutput("async rst resp0_val", imemresp0_val, 1'b0);
        checkOutput("async rst resp1_val", imemresp1_val, 1'b0);
        @(negedge clk);
        memresp_val = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("held rst outstanding", outstanding, 3'd0);

        // First fire on the first edge after release, port 0 favoured
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("post rst rdy0", imemreq0_rdy, 1'b1);
        checkOutput("post rst rdy1", imemreq1_rdy, 1'b0);
        checkOutput("post rst memreq_msg", memreq_msg, reqMsg(32'h400));
        @(posedge clk);
        #1;
        checkOutput("first fire outstanding", outstanding, 3'd1);
        imemreq0_val = 1'b0;
        imemreq1_val = 1'b0;

        // Reset while a request is outstanding discards it; its late response is an orphan
        #2;
        reset = 1'b0;
        #1;
        checkOutput("discard outstanding", outstanding, 3'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        memresp_val = 1'b1;
        memresp_msg = 35'h99;
        @(negedge clk);
        checkOutput("late resp0_val", imemresp0_val, 1'b0);
        checkOutput("late resp1_val", imemresp1_val, 1'b0);
        checkOutput("late outstanding", outstanding, 3'd0);
        @(posedge clk);
        #1;
        memresp_val = 1'b0;
        checkOutput("late err_orphan", err_orphan, 1'b1);
        checkOutput("late outstanding after", outstanding, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_imem_arbiter.md
RISCV_IMEM_ARBITER -- requirements
Module: riscv_imem_arbiter

Interface
REQ-001 Parameter: P_DEPTH, default 4, maximum number of outstanding requests (power of two, 2..16).
REQ-002 Parameter: P_CW, default clog2(P_DEPTH)+1, width of the outstanding-count output.
REQ-003 One clock; reset is asynchronous and active-low: clk, reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 imemreq0_msg  input  67  port-0 request, VC_MEM_REQ_MSG_SZ(32,32) format.
REQ-007 imemreq0_val  input  1  port-0 request valid.
REQ-008 imemreq0_rdy  output  1  port-0 request accepted this cycle.
REQ-009 imemreq1_msg / imemreq1_val / imemreq1_rdy  same as REQ-006..008, for port 1.
REQ-010 memreq_msg  output  67  merged request to the instruction memory.
REQ-011 memreq_val  output  1  merged request valid.
REQ-012 memreq_rdy  input  1  memory ready.
REQ-013 memresp_msg  input  35  VC_MEM_RESP_MSG_SZ(32) response.
REQ-014 memresp_val  input  1  response valid; there is no back-pressure.
REQ-015 imemresp0_msg / imemresp0_val  output  35 / 1  response routed to port 0.
REQ-016 imemresp1_msg / imemresp1_val  output  35 / 1  response routed to port 1.
REQ-017 outstanding  output  P_CW  number of requests issued but not yet answered.
REQ-018 err_orphan  output  1  sticky flag: a response arrived with no request outstanding.

Function
REQ-019 Grant is chosen round-robin from the request-valid signals only, never from memreq_rdy.
- A last-grant pointer records which port won most recently.
- When both ports are valid, the port not granted last wins.
- After reset the pointer favours port 0.
REQ-020 full = (outstanding == P_DEPTH).
- memreq_val = (imemreq0_val | imemreq1_val) & !full.
- memreq_msg = the granted port's message, passed through combinationally.
REQ-021 imemreqN_rdy = grantN & memreq_rdy & !full.
- At most one rdy is asserted per cycle.
- A fire is rdy & val.
REQ-022 On a fire:
- The granted port id is pushed into an in-order ID FIFO of depth P_DEPTH.
- The last-grant pointer updates to that port.
- The pointer does not change in any cycle without a fire.
REQ-023 A valid request that loses arbitration or is not accepted produces no state change. The requester must hold its message stable until it sees rdy.
REQ-024 When memresp_val=1 and the FIFO is non-empty, the head id is popped in the same cycle.
- memresp_msg is driven to both imemresp0_msg and imemresp1_msg unchanged.
- Only imemresp<head>_val is asserted; the other val stays 0.
- Response latency through the block is zero cycles.
REQ-025 When memresp_val=1 and the FIFO is empty:
- Both resp vals stay 0.
- err_orphan sets and holds until reset.
- outstanding is unchanged.
REQ-026 Push and pop in the same cycle leave outstanding unchanged and keep FIFO order.
- This applies at full as well: a pop does not free a slot for a same-cycle push, so memreq_val is still 0 when full.
REQ-027 FIFO read and write pointers wrap modulo P_DEPTH.
- outstanding = pushes − pops and never exceeds P_DEPTH or goes below 0.
REQ-028 Responses return in issue order; the block does no reordering.

Reset
REQ-029 While reset=0, all of the following hold asynchronously:
- FIFO is empty and outstanding=0.
- err_orphan=0 and the last-grant pointer favours port 0.
- memreq_val=0, imemreq0_rdy=0, imemreq1_rdy=0.
- imemresp0_val=0 and imemresp1_val=0.
REQ-030 Reset asserted mid-operation discards all outstanding ids.
- Responses arriving after reset release count as orphans.
REQ-031 The first fire can occur in the first rising edge after reset deasserts.

Verification
REQ-032 Both valid, memreq_rdy=1, addrs 0x100 (port 0) and 0x104 (port 1), for 2 cycles -> cycle 1 issues 0x100 with imemreq0_rdy=1; cycle 2 issues 0x104 with imemreq1_rdy=1; outstanding=2.
REQ-033 Responses 0xAAAA then 0xBBBB follow REQ-032 -> imemresp0_val carries 0xAAAA, then imemresp1_val carries 0xBBBB; outstanding returns to 0.
REQ-034 Port 0 only, memreq_rdy=1, 4 requests with no responses (P_DEPTH=4) -> outstanding=4; a 5th request sees memreq_val=0 and imemreq0_rdy=0.
REQ-035 At full, one response plus a pending request in the same cycle -> the response routes correctly; the request is not issued that cycle and is issued the next cycle; outstanding goes 4→3→4.
REQ-036 memresp_val=1 with outstanding=0 -> both resp vals stay 0 and err_orphan=1 persists; reset=0 clears it.
REQ-037 memreq_rdy=0 for 3 cycles with both valid -> no rdy asserted, pointer unchanged, port 0 wins when rdy returns.
